// File: rtl/gray_code_pkg.sv
// -----------------------------------------------------------------------------
// gray_code_pkg
// Shared definitions for the Gray code converter:
//   - DEFAULT_WIDTH / MAX_WIDTH : default and largest supported code width
//   - dir_e                     : conversion direction of a gray_code_stage
//   - gray_encode / gray_decode : pure conversion functions. They operate on a
//                                 MAX_WIDTH container, and the 'width' argument
//                                 selects how many low bits are meaningful.
// -----------------------------------------------------------------------------
package gray_code_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 32;

  typedef enum logic {
    DIR_ENCODE = 1'b0,
    DIR_DECODE = 1'b1
  } dir_e;

  // Mask that keeps the low 'width' bits of a MAX_WIDTH container.
  function automatic logic [MAX_WIDTH-1:0] width_mask(input int width);
    logic [MAX_WIDTH-1:0] mask;
    if (width >= MAX_WIDTH) begin
      mask = '1;
    end else begin
      mask = (32'd1 << width) - 32'd1;
    end
    return mask;
  endfunction

  // Binary to Gray. Bits above 'width' are cleared first, so the code's MSB
  // sees a zero above it and passes through unchanged.
  function automatic logic [MAX_WIDTH-1:0] gray_encode(input logic [MAX_WIDTH-1:0] value,
                                                       input int                   width);
    logic [MAX_WIDTH-1:0] b;
    b = value & width_mask(width);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: prefix XOR running down from the MSB. Cleared upper bits
  // contribute nothing, so the chain starts at the code's own MSB.
  function automatic logic [MAX_WIDTH-1:0] gray_decode(input logic [MAX_WIDTH-1:0] value,
                                                       input int                   width);
    logic [MAX_WIDTH-1:0] g;
    logic [MAX_WIDTH-1:0] b;
    g = value & width_mask(width);
    b = '0;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_code_converter_if.sv
// -----------------------------------------------------------------------------
// gray_code_converter_if
// Bundles the data/valid signals of both conversion paths.
//   master : drives bin_in/bin_in_vld, gray_in/gray_in_vld; observes outputs
//   slave  : the converter; drives gray_out/gray_out_vld, bin_out/bin_out_vld,
//            rt_err
// Parameter WIDTH must match the WIDTH of the converter attached to it.
// -----------------------------------------------------------------------------
interface gray_code_converter_if
  import gray_code_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] bin_in;
  logic             bin_in_vld;
  logic [WIDTH-1:0] gray_out;
  logic             gray_out_vld;

  logic [WIDTH-1:0] gray_in;
  logic             gray_in_vld;
  logic [WIDTH-1:0] bin_out;
  logic             bin_out_vld;

  logic             rt_err;

  modport master (
    output bin_in, bin_in_vld, gray_in, gray_in_vld,
    input  gray_out, gray_out_vld, bin_out, bin_out_vld, rt_err
  );

  modport slave (
    input  bin_in, bin_in_vld, gray_in, gray_in_vld,
    output gray_out, gray_out_vld, bin_out, bin_out_vld, rt_err
  );

endinterface

// File: rtl/gray_code_stage.sv
// -----------------------------------------------------------------------------
// gray_code_stage
// One registered conversion path (1 cycle latency, no backpressure).
//   clk, rst  : clock, synchronous active-high reset
//   in_data   : value to convert, in_vld qualifies it
//   out_data  : converted value; loads only when in_vld, otherwise holds
//   out_vld   : in_vld delayed by one cycle
// Parameter DIR selects encode (binary->Gray) or decode (Gray->binary).
// -----------------------------------------------------------------------------
module gray_code_stage
  import gray_code_pkg::*;
#(
  parameter int   WIDTH = DEFAULT_WIDTH,
  parameter dir_e DIR   = DIR_ENCODE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_vld,
  output logic [WIDTH-1:0] out_data,
  output logic             out_vld
);

  logic [MAX_WIDTH-1:0] conv_wide;
  logic [WIDTH-1:0]     data_reg;
  logic [WIDTH-1:0]     data_next;
  logic                 vld_reg;

  if (DIR == DIR_ENCODE) begin : g_encode
    assign conv_wide = gray_encode(MAX_WIDTH'(in_data), WIDTH);
  end else begin : g_decode
    assign conv_wide = gray_decode(MAX_WIDTH'(in_data), WIDTH);
  end

  // Hold the last result whenever the input is not valid.
  always_comb begin
    data_next = data_reg;
    if (in_vld) begin
      data_next = conv_wide[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg <= '0;
      vld_reg  <= 1'b0;
    end else begin
      data_reg <= data_next;
      vld_reg  <= in_vld;
    end
  end

  assign out_data = data_reg;
  assign out_vld  = vld_reg;

endmodule

// File: rtl/gray_code_converter.sv
// -----------------------------------------------------------------------------
// gray_code_converter
// Independent registered binary->Gray and Gray->binary converters.
//   clk  : single clock, all state on the rising edge
//   rst  : synchronous active-high reset, wins over valid inputs
//   bus  : gray_code_converter_if.slave
//          bin_in/bin_in_vld   -> gray_out/gray_out_vld (1 cycle)
//          gray_in/gray_in_vld -> bin_out/bin_out_vld   (1 cycle)
//          rt_err              : round-trip mismatch flag
// Optional feature, macro GRAY_ROUNDTRIP_CHECK_EN:
//   defined   - gray_out is decoded again and compared with a registered copy
//               of the binary value that produced it; rt_err goes high the
//               cycle after a valid gray_out that fails to round-trip.
//   undefined - rt_err is constant 0 and no check logic is built.
// -----------------------------------------------------------------------------
module gray_code_converter
  import gray_code_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  gray_code_converter_if.slave  bus
);

  gray_code_stage #(
    .WIDTH (WIDTH),
    .DIR   (DIR_ENCODE)
  ) u_encode (
    .clk      (clk),
    .rst      (rst),
    .in_data  (bus.bin_in),
    .in_vld   (bus.bin_in_vld),
    .out_data (bus.gray_out),
    .out_vld  (bus.gray_out_vld)
  );

  gray_code_stage #(
    .WIDTH (WIDTH),
    .DIR   (DIR_DECODE)
  ) u_decode (
    .clk      (clk),
    .rst      (rst),
    .in_data  (bus.gray_in),
    .in_vld   (bus.gray_in_vld),
    .out_data (bus.bin_out),
    .out_vld  (bus.bin_out_vld)
  );

`ifdef GRAY_ROUNDTRIP_CHECK_EN
  // bin_copy_reg loads under the same condition as the encode register, so it
  // always holds the binary source of the current gray_out.
  logic [WIDTH-1:0]     bin_copy_reg;
  logic [WIDTH-1:0]     bin_copy_next;
  logic [MAX_WIDTH-1:0] gray_back_wide;
  logic                 rt_err_reg;
  logic                 rt_err_next;

  assign gray_back_wide = gray_decode(MAX_WIDTH'(bus.gray_out), WIDTH);

  always_comb begin
    bin_copy_next = bin_copy_reg;
    if (bus.bin_in_vld) begin
      bin_copy_next = bus.bin_in;
    end
    rt_err_next = bus.gray_out_vld && (gray_back_wide[WIDTH-1:0] != bin_copy_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_copy_reg <= '0;
      rt_err_reg   <= 1'b0;
    end else begin
      bin_copy_reg <= bin_copy_next;
      rt_err_reg   <= rt_err_next;
    end
  end

  assign bus.rt_err = rt_err_reg;
`else
  assign bus.rt_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_code_converter.sv
// -----------------------------------------------------------------------------
// tb_gray_code_converter
// Self-checking bench for gray_code_converter at WIDTH=4 and WIDTH=8.
// -----------------------------------------------------------------------------
module tb_gray_code_converter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gray_code_converter_if #(.WIDTH(4)) bus4 ();
  gray_code_converter_if #(.WIDTH(8)) bus8 ();

  gray_code_converter #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  gray_code_converter #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] bin;
    logic       bin_vld;
    logic [3:0] gray;
    logic       gray_vld;
    logic [3:0] exp_gray;
    logic       exp_gray_vld;
    logic [3:0] exp_bin;
    logic       exp_bin_vld;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: Gray code of n is n XOR floor(n/2).
  function automatic int unsigned model_enc(input int unsigned v);
    return v ^ (v / 2);
  endfunction

  // Reference decode: search for the binary value whose Gray code matches.
  function automatic int unsigned model_dec(input int unsigned g, input int w);
    int unsigned r = 0;
    for (int unsigned v = 0; v < (32'd1 << w); v++) begin
      if (model_enc(v) == g) r = v;
    end
    return r;
  endfunction

  initial begin
    logic [3:0]  sweep_exp [9];
    logic [3:0]  prev_gray;
    logic [7:0]  prev8;
    int unsigned exp_gray, exp_bin;
    logic        exp_gv, exp_bv;
    int unsigned rb, rg;
    logic        rbv, rgv;

    sweep_exp = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                  4'b0111, 4'b0101, 4'b0100, 4'b1100};
    for (int i = 0; i < 9; i++) begin
      vecs[i] = '{4'(i), 1'b1, 4'd0, 1'b0, sweep_exp[i], 1'b1, 4'd0, 1'b0};
    end
    // Both paths at once, then decode-only, then idle hold.
    vecs[9]  = '{4'b0101, 1'b1, 4'b1100, 1'b1, 4'b0111, 1'b1, 4'b1000, 1'b1};
    vecs[10] = '{4'b0000, 1'b0, 4'b0111, 1'b1, 4'b0111, 1'b0, 4'b0101, 1'b1};
    vecs[11] = '{4'b1010, 1'b0, 4'b0000, 1'b0, 4'b0111, 1'b0, 4'b0101, 1'b0};

    rst = 1'b1;
    bus4.bin_in = '0; bus4.bin_in_vld = 1'b0; bus4.gray_in = '0; bus4.gray_in_vld = 1'b0;
    bus8.bin_in = '0; bus8.bin_in_vld = 1'b0; bus8.gray_in = '0; bus8.gray_in_vld = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_gray_out", 32'(bus4.gray_out), 0);
    check("rst_gray_vld", 32'(bus4.gray_out_vld), 0);
    check("rst_bin_out", 32'(bus4.bin_out), 0);
    check("rst_bin_vld", 32'(bus4.bin_out_vld), 0);
    check("rst_rt_err", 32'(bus4.rt_err), 0);
    check("rst8_gray_out", 32'(bus8.gray_out), 0);
    $display("reset: gray_out=%b bin_out=%b", bus4.gray_out, bus4.bin_out);

    // Reset beats a valid input; first edge after release accepts normally.
    bus4.bin_in = 4'b1111; bus4.bin_in_vld = 1'b1;
    tick();
    check("rstprec_gray_out", 32'(bus4.gray_out), 0);
    check("rstprec_gray_vld", 32'(bus4.gray_out_vld), 0);
    rst = 1'b0;
    tick();
    check("release_gray_out", 32'(bus4.gray_out), 32'b1000);
    check("release_gray_vld", 32'(bus4.gray_out_vld), 1);
    $display("release: bin_in=1111 gray_out=%b", bus4.gray_out);

    // Vector table
    for (int i = 0; i < 12; i++) begin
      bus4.bin_in = vecs[i].bin;   bus4.bin_in_vld  = vecs[i].bin_vld;
      bus4.gray_in = vecs[i].gray; bus4.gray_in_vld = vecs[i].gray_vld;
      tick();
      check($sformatf("vec%0d_gray_out", i), 32'(bus4.gray_out), 32'(vecs[i].exp_gray));
      check($sformatf("vec%0d_gray_vld", i), 32'(bus4.gray_out_vld), 32'(vecs[i].exp_gray_vld));
      check($sformatf("vec%0d_bin_out", i), 32'(bus4.bin_out), 32'(vecs[i].exp_bin));
      check($sformatf("vec%0d_bin_vld", i), 32'(bus4.bin_out_vld), 32'(vecs[i].exp_bin_vld));
      check($sformatf("vec%0d_rt_err", i), 32'(bus4.rt_err), 0);
      $display("vec %0d: bin_in=%b/%b gray_in=%b/%b -> gray_out=%b/%b bin_out=%b/%b",
               i, vecs[i].bin, vecs[i].bin_vld, vecs[i].gray, vecs[i].gray_vld,
               bus4.gray_out, bus4.gray_out_vld, bus4.bin_out, bus4.bin_out_vld);
    end

    // Loopback over all codes, including the wrap 15 -> 0.
    prev_gray = '0;
    for (int c = 0; c <= 17; c++) begin
      bus4.bin_in      = 4'(c % 16);
      bus4.bin_in_vld  = (c <= 16);
      bus4.gray_in     = bus4.gray_out;
      bus4.gray_in_vld = bus4.gray_out_vld;
      tick();
      if (c <= 16) begin
        check($sformatf("loop%0d_gray", c), 32'(bus4.gray_out), model_enc(c % 16));
        if (c >= 1)
          check($sformatf("loop%0d_onebit", c), $countones(prev_gray ^ bus4.gray_out), 1);
        prev_gray = bus4.gray_out;
      end
      if (c >= 1) begin
        check($sformatf("loop%0d_bin", c), 32'(bus4.bin_out), (c - 1) % 16);
        check($sformatf("loop%0d_bin_vld", c), 32'(bus4.bin_out_vld), 1);
      end
      check($sformatf("loop%0d_rt_err", c), 32'(bus4.rt_err), 0);
      $display("loop %0d: gray_out=%b bin_out=%b rt_err=%b",
               c, bus4.gray_out, bus4.bin_out, bus4.rt_err);
    end

    // Random traffic against the reference model.
    exp_gray = bus4.gray_out; exp_bin = bus4.bin_out;
    for (int n = 0; n < 120; n++) begin
      rb = $urandom_range(0, 15); rg = $urandom_range(0, 15);
      rbv = 1'($urandom % 2);     rgv = 1'($urandom % 2);
      bus4.bin_in = 4'(rb);  bus4.bin_in_vld  = rbv;
      bus4.gray_in = 4'(rg); bus4.gray_in_vld = rgv;
      tick();
      if (rbv) exp_gray = model_enc(rb);
      if (rgv) exp_bin  = model_dec(rg, 4);
      exp_gv = rbv; exp_bv = rgv;
      check("rand_gray_out", 32'(bus4.gray_out), exp_gray);
      check("rand_gray_vld", 32'(bus4.gray_out_vld), 32'(exp_gv));
      check("rand_bin_out", 32'(bus4.bin_out), exp_bin);
      check("rand_bin_vld", 32'(bus4.bin_out_vld), 32'(exp_bv));
      check("rand_rt_err", 32'(bus4.rt_err), 0);
      $display("rand %0d: bin=%0d/%b gray=%0d/%b -> gray_out=%b bin_out=%b",
               n, rb, rbv, rg, rgv, bus4.gray_out, bus4.bin_out);
    end

    // Mid-stream reset discards in-flight data on both paths.
    rst = 1'b1;
    bus4.bin_in = 4'b0110; bus4.bin_in_vld = 1'b1;
    bus4.gray_in = 4'b1011; bus4.gray_in_vld = 1'b1;
    tick();
    check("midrst_gray_out", 32'(bus4.gray_out), 0);
    check("midrst_bin_out", 32'(bus4.bin_out), 0);
    check("midrst_gray_vld", 32'(bus4.gray_out_vld), 0);
    check("midrst_bin_vld", 32'(bus4.bin_out_vld), 0);
    rst = 1'b0;
    bus4.bin_in = 4'b0011; bus4.gray_in = 4'b0010;
    tick();
    check("postrst_gray_out", 32'(bus4.gray_out), 32'b0010);
    check("postrst_bin_out", 32'(bus4.bin_out), 32'b0011);
    $display("midrst: gray_out=%b bin_out=%b", bus4.gray_out, bus4.bin_out);
    bus4.bin_in_vld = 1'b0; bus4.gray_in_vld = 1'b0;

    // WIDTH=8 corner values.
    bus8.bin_in = 8'hFF; bus8.bin_in_vld = 1'b1;
    bus8.gray_in = 8'h80; bus8.gray_in_vld = 1'b1;
    tick();
    check("w8_gray_out", 32'(bus8.gray_out), 32'h80);
    check("w8_bin_out", 32'(bus8.bin_out), 32'hFF);
    prev8 = bus8.gray_out;
    bus8.bin_in = 8'h00; bus8.gray_in_vld = 1'b0;
    tick();
    check("w8_wrap_gray", 32'(bus8.gray_out), 0);
    check("w8_wrap_onebit", $countones(prev8 ^ bus8.gray_out), 1);
    check("w8_bin_hold", 32'(bus8.bin_out), 32'hFF);
    check("w8_rt_err", 32'(bus8.rt_err), 0);
    $display("w8: 0xFF->0x%0h 0x80->0x%0h", prev8, bus8.bin_out);
    bus8.bin_in_vld = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_code_converter.md
GRAY_CODE_CONVERTER -- requirements
Module: gray_code_converter

Interface
- REQ-001: Parameter WIDTH, default 4; data width of all code buses; legal range 2..32.
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: rst  input  1  reset, synchronous and active-high.
- REQ-004: bin_in  input  WIDTH  binary value to encode.
- REQ-005: bin_in_vld  input  1  bin_in is valid this cycle.
- REQ-006: gray_out  output  WIDTH  registered Gray encoding of bin_in.
- REQ-007: gray_out_vld  output  1  gray_out is valid.
- REQ-008: gray_in  input  WIDTH  Gray value to decode.
- REQ-009: gray_in_vld  input  1  gray_in is valid this cycle.
- REQ-010: bin_out  output  WIDTH  registered binary decoding of gray_in.
- REQ-011: bin_out_vld  output  1  bin_out is valid.
- REQ-012: rt_err  output  1  round-trip mismatch flag (see Configuration).

Function
- REQ-013: Encode SHALL be gray = bin XOR (bin >> 1); MSB passes through unchanged.
- REQ-014: Decode SHALL be bin[WIDTH-1] = gray[WIDTH-1]; bin[i] = bin[i+1] XOR gray[i] for i below WIDTH-1 (prefix XOR from MSB).
- REQ-015: Each path SHALL have exactly 1 cycle latency: value sampled with its valid at edge N appears on the output after edge N.
- REQ-016: Output data registers SHALL load only when the matching input valid is high; otherwise they hold the last value.
- REQ-017: The *_vld outputs SHALL follow their input valids with 1-cycle delay (no backpressure; a new input is accepted every cycle).
- REQ-018: Encode and decode paths SHALL be fully independent; simultaneous valids on both are processed in the same cycle.
- REQ-019: Adjacent binary values (including wrap from all-ones to zero) SHALL yield Gray codes differing in exactly one bit.
- REQ-020: No overflow or saturation exists; all WIDTH input codes are legal.

Reset
- REQ-021: While rst is high at a clock edge: gray_out=0, bin_out=0, gray_out_vld=0, bin_out_vld=0, rt_err=0.
- REQ-022: Reset SHALL take precedence over valid inputs in the same cycle; in-flight data is discarded.
- REQ-023: Valid inputs on the first edge after rst deasserts SHALL be accepted normally.

Configuration
- REQ-024: Macro GRAY_ROUNDTRIP_CHECK_EN.
- REQ-025: With the macro defined: gray_out is decoded internally and compared with the registered copy of the encoded bin_in; rt_err is registered high in the cycle after any gray_out_vld cycle where they differ, and low otherwise.
- REQ-026: Without the macro: rt_err is tied to 0 and no check logic exists; port list unchanged.

Structure
- REQ-027: A shared package gray_code_pkg SHALL hold pure encode/decode functions parameterised on width and the default width constant.
- REQ-028: One sub-module gray_code_stage (one registered conversion path with direction parameter) SHALL be instantiated twice, once for encode and once for decode.

Verification
- REQ-029: Sweep bin_in 0000..1000 with valid every cycle -> gray_out 0000,0001,0011,0010,0110,0111,0101,0100,1100, each 1 cycle later.
- REQ-030: Loop gray_out into gray_in over all 16 codes -> bin_out equals the original bin_in 2 cycles after entry; rt_err stays 0 with the macro defined.
- REQ-031: gray_in=0111 with valid -> bin_out=0101 next cycle; valid low next -> bin_out holds 0101 and bin_out_vld=0.
- REQ-032: Assert rst with bin_in_vld=1, bin_in=1111 -> next cycle gray_out=0000 and gray_out_vld=0; after release, bin_in=1111 -> 1000.
- REQ-033: WIDTH=8: bin_in=0xFF -> gray_out=0x80; gray_in=0x80 -> bin_out=0xFF; 0xFF followed by 0x00 differs in one Gray bit.
- REQ-034: Simultaneous bin_in=0101 and gray_in=1100, both valid -> same cycle outputs gray_out=0111 and bin_out=1000.
